// File: rtl/mux_drv_pkg.sv
// mux_drv_pkg: shared widths, bit offsets and states for the multiplexed project driver
package mux_drv_pkg;
  localparam int IW_W = 18;
  localparam int OW_W = 24;
  localparam int IW_CLK = 0;
  localparam int IW_RSTN = 1;
  localparam int IW_UI = 2;
  localparam int IW_UIO = 10;
  localparam int OW_UO = 0;
  localparam int OW_UIO = 8;
  localparam int OW_OE = 16;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, SAMPLE, RESP} state_t;
endpackage

// File: rtl/mux_drv_phase_timer.sv
// mux_drv_phase_timer: loadable HALF_CYC down-counter, done on the last cycle of a phase
module mux_drv_phase_timer #(
  parameter int HALF_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam int TW = $clog2(HALF_CYC + 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || load) cnt <= TW'(HALF_CYC - 1);
    else if (cnt != '0) cnt <= cnt - TW'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/mux_proj_driver.sv
// mux_proj_driver: selects one project, pulses its clock ncyc times and returns its sampled outputs
module mux_proj_driver
  import mux_drv_pkg::*;
#(
  parameter int N_PROJ = 16,
  parameter int SEL_W = 4,
  parameter int HALF_CYC = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [7:0]        cmd_ui,
  input  logic [7:0]        cmd_uio,
  input  logic              cmd_prst,
  input  logic [CNT_W-1:0]  cmd_ncyc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_uo,
  output logic [7:0]        rsp_uio,
  output logic [7:0]        rsp_oe,
  output logic              rsp_err,
  output logic [SEL_W-1:0]  proj_sel,
  output logic [N_PROJ-1:0] proj_ena,
  output logic [IW_W-1:0]   proj_iw,
  input  logic [OW_W-1:0]   proj_ow
);
  state_t state, state_next;
  logic [CNT_W-1:0] pulses;
  logic err, done, accept, phase_end, sel_err;
  assign accept = state == IDLE && cmd_valid && cmd_ready;
  assign phase_end = done && (state == SETUP || state == HIGH || state == LOW);
  assign sel_err = 32'(cmd_sel) >= N_PROJ;
  mux_drv_phase_timer #(.HALF_CYC(HALF_CYC)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(accept || phase_end),
    .done(done)
  );
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? SETUP : IDLE;
      SETUP:   state_next = !done ? SETUP : pulses != '0 ? HIGH : SAMPLE;
      HIGH:    state_next = done ? LOW : HIGH;
      LOW:     state_next = !done ? LOW : pulses > CNT_W'(1) ? HIGH : SAMPLE;
      SAMPLE:  state_next = RESP;
      RESP:    state_next = rsp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end
  // Outputs derive from state_next so they are registered yet aligned with the state they belong to
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_uo <= '0;
      rsp_uio <= '0;
      rsp_oe <= '0;
      rsp_err <= 1'b0;
      proj_sel <= '0;
      proj_ena <= '0;
      proj_iw <= '0;
      pulses <= '0;
      err <= 1'b0;
    end else begin
      state <= state_next;
      cmd_ready <= state_next == IDLE;
      rsp_valid <= state_next == RESP;
      proj_iw[IW_CLK] <= state_next == HIGH;
      if (accept) begin
        proj_iw[IW_W-1:IW_RSTN] <= {cmd_uio, cmd_ui, ~cmd_prst};
        proj_sel <= cmd_sel;
        proj_ena <= sel_err ? '0 : {{(N_PROJ-1){1'b0}}, 1'b1} << cmd_sel;
        err <= sel_err;
        pulses <= cmd_ncyc;
      end
      if (state == LOW && done) pulses <= pulses - CNT_W'(1);
      if (state == SAMPLE) begin
        rsp_uo <= err ? '0 : proj_ow[OW_UO+:8];
        rsp_uio <= err ? '0 : proj_ow[OW_UIO+:8];
        rsp_oe <= err ? '0 : proj_ow[OW_OE+:8];
        rsp_err <= err;
      end
    end
endmodule

// File: tb/tb_mux_proj_driver.sv
// tb_mux_proj_driver: directed bench with a counter project model behind the output mux
module tb_mux_proj_driver;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_prst = 0, rsp_ready = 0;
  logic [4:0] cmd_sel = 0;
  logic [7:0] cmd_ui = 0, cmd_uio = 0, cmd_ncyc = 0;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_uo, rsp_uio, rsp_oe;
  logic [4:0] proj_sel;
  logic [15:0] proj_ena;
  logic [17:0] proj_iw;
  logic [23:0] proj_ow;
  logic [7:0] pcnt = 0;
  int checks = 0, errors = 0, cyc = 0, edges = 0;
  int t0, lat;
  logic [31:0] hi_mask;
  logic [17:0] iw1;
  logic [15:0] ena1;
  logic rstn_or, rstn_and;
  mux_proj_driver #(.N_PROJ(16), .SEL_W(5), .HALF_CYC(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_ui(cmd_ui), .cmd_uio(cmd_uio), .cmd_prst(cmd_prst), .cmd_ncyc(cmd_ncyc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uo(rsp_uo), .rsp_uio(rsp_uio),
    .rsp_oe(rsp_oe), .rsp_err(rsp_err), .proj_sel(proj_sel), .proj_ena(proj_ena),
    .proj_iw(proj_iw), .proj_ow(proj_ow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge proj_iw[0]) edges = edges + 1;
  // Project model: counter clocked by the packed project clock, cleared by its rst_n
  always @(posedge proj_iw[0] or negedge proj_iw[1])
    if (!proj_iw[1]) pcnt <= 0;
    else pcnt <= pcnt + 1;
  assign proj_ow = {8'hF0 ^ pcnt, proj_iw[17:10], pcnt};
  task automatic do_cmd(input logic [4:0] sel, input logic [7:0] ui, uio, input logic prst, input logic [7:0] n);
    cmd_sel = sel; cmd_ui = ui; cmd_uio = uio; cmd_prst = prst; cmd_ncyc = n;
    cmd_valid = 1; edges = 0;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready); end
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 0; iw1 = proj_iw; ena1 = proj_ena; hi_mask = 0; rstn_or = 0; rstn_and = 1; lat = -1;
    for (int i = 1; i < 2000; i++) begin
      if (i < 32) hi_mask[i] = proj_iw[0];
      rstn_or = rstn_or | proj_iw[1];
      rstn_and = rstn_and & proj_iw[1];
      if (rsp_valid === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
    checks++;
    if (lat < 0) begin errors++; $display("FAIL rsp_timeout: rsp_valid never rose, required within 2000 cycles"); end
  endtask
  task automatic take_rsp;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({proj_iw, proj_ena, proj_sel} !== '0) begin errors++; $display("FAIL reset_proj: iw=%h ena=%h sel=%h required 0", proj_iw, proj_ena, proj_sel); end
    checks++;
    if ({rsp_valid, rsp_uo, rsp_uio, rsp_oe, rsp_err, cmd_ready} !== '0) begin errors++; $display("FAIL reset_rsp: valid=%b uo=%h uio=%h oe=%h err=%b ready=%b required 0", rsp_valid, rsp_uo, rsp_uio, rsp_oe, rsp_err, cmd_ready); end
    rst = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready); end
  endtask
  task automatic test_basic;
    do_cmd(5'd3, 8'hA5, 8'h3C, 1'b0, 8'd1);
    checks++;
    if (iw1 !== 18'h0F296) begin errors++; $display("FAIL basic_iw: %h required 0F296", iw1); end
    checks++;
    if (ena1 !== 16'h0008 || proj_sel !== 5'd3) begin errors++; $display("FAIL basic_ena: ena=%h sel=%0d required 0008/3", ena1, proj_sel); end
    checks++;
    if (hi_mask !== 32'h18 || edges !== 1) begin errors++; $display("FAIL basic_clk: mask=%h edges=%0d required 18/1", hi_mask, edges); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: %0d required 8", lat); end
    checks++;
    if ({rsp_uo, rsp_uio, rsp_oe, rsp_err} !== {8'h01, 8'h3C, 8'hF1, 1'b0}) begin errors++; $display("FAIL basic_rsp: uo=%h uio=%h oe=%h err=%b required 01/3C/F1/0", rsp_uo, rsp_uio, rsp_oe, rsp_err); end
    take_rsp;
  endtask
  task automatic test_prst;
    do_cmd(5'd5, 8'h11, 8'h22, 1'b1, 8'd2);
    checks++;
    if (rstn_or !== 1'b0) begin errors++; $display("FAIL prst_rstn: rst_n rose during command, required low"); end
    checks++;
    if (hi_mask !== 32'h198 || edges !== 2 || lat !== 12) begin errors++; $display("FAIL prst_timing: mask=%h edges=%0d lat=%0d required 198/2/12", hi_mask, edges, lat); end
    checks++;
    if ({rsp_uo, rsp_uio, rsp_oe} !== {8'h00, 8'h22, 8'hF0}) begin errors++; $display("FAIL prst_rsp: uo=%h uio=%h oe=%h required 00/22/F0", rsp_uo, rsp_uio, rsp_oe); end
    take_rsp;
  endtask
  task automatic test_count;
    do_cmd(5'd5, 8'h01, 8'h02, 1'b0, 8'd5);
    checks++;
    if (rstn_and !== 1'b1) begin errors++; $display("FAIL count_rstn: rst_n low during command, required high"); end
    checks++;
    if (lat !== 24 || edges !== 5 || rsp_uo !== 8'd5) begin errors++; $display("FAIL count_five: lat=%0d edges=%0d uo=%0d required 24/5/5", lat, edges, rsp_uo); end
    take_rsp;
    do_cmd(5'd5, 8'h01, 8'h02, 1'b0, 8'd0);
    checks++;
    if (lat !== 4 || edges !== 0 || hi_mask !== 0) begin errors++; $display("FAIL count_zero_timing: lat=%0d edges=%0d mask=%h required 4/0/0", lat, edges, hi_mask); end
    checks++;
    if (rsp_uo !== 8'd5) begin errors++; $display("FAIL count_zero_rsp: uo=%0d required 5", rsp_uo); end
    take_rsp;
  endtask
  task automatic test_err;
    do_cmd(5'd16, 8'hFF, 8'hFF, 1'b0, 8'd1);
    checks++;
    if (ena1 !== 16'h0 || proj_sel !== 5'd16) begin errors++; $display("FAIL err_ena: ena=%h sel=%0d required 0000/16", ena1, proj_sel); end
    checks++;
    if (lat !== 8 || edges !== 1) begin errors++; $display("FAIL err_timing: lat=%0d edges=%0d required 8/1", lat, edges); end
    checks++;
    if ({rsp_err, rsp_uo, rsp_uio, rsp_oe} !== {1'b1, 24'h0}) begin errors++; $display("FAIL err_rsp: err=%b uo=%h uio=%h oe=%h required 1/00/00/00", rsp_err, rsp_uo, rsp_uio, rsp_oe); end
    take_rsp;
  endtask
  task automatic test_backpressure;
    do_cmd(5'd2, 8'h00, 8'h55, 1'b0, 8'd1);
    checks++;
    if (ena1 !== 16'h0004) begin errors++; $display("FAIL bp_ena: %h required 0004", ena1); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_uo, rsp_uio, rsp_oe, rsp_err} !== {2'b10, 8'h07, 8'h55, 8'hF7, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b ready=%b uo=%h uio=%h oe=%h err=%b required 1/0/07/55/F7/0", i, rsp_valid, cmd_ready, rsp_uo, rsp_uio, rsp_oe, rsp_err);
      end
    end
    take_rsp;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid, cmd_ready); end
  endtask
  task automatic test_reset_mid;
    logic seen;
    cmd_sel = 5'd9; cmd_ui = 8'h5A; cmd_uio = 8'hC3; cmd_prst = 0; cmd_ncyc = 8'd4; cmd_valid = 1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 50 && proj_iw[0] !== 1'b1; i++) @(negedge clk);
    checks++;
    if (proj_iw[0] !== 1'b1) begin errors++; $display("FAIL mid_high: project clk=%b required 1", proj_iw[0]); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (proj_iw !== '0 || proj_ena !== '0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: iw=%h ena=%h valid=%b required 0/0/0", proj_iw, proj_ena, rsp_valid); end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | (rsp_valid === 1'b1);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_rsp: rsp_valid=1 after abort, required 0"); end
    do_cmd(5'd7, 8'h00, 8'h00, 1'b0, 8'd2);
    checks++;
    if (lat !== 12 || rsp_uo !== 8'd2 || rsp_err !== 1'b0) begin errors++; $display("FAIL mid_recover: lat=%0d uo=%0d err=%b required 12/2/0", lat, rsp_uo, rsp_err); end
    take_rsp;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_prst;
    test_count;
    test_err;
    test_backpressure;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_proj_driver.md
Name: mux_proj_driver

Overview:
- Host-side driver for the multiplexed project array: accepts a command and selects one project with a one-hot enable.
- Drives that project's packed 18-bit input word, including the generated project clock and active-low project reset.
- Toggles the project clock a commanded number of times, then samples the project's packed 24-bit output word and returns it through a valid/ready response.
- Sits between a host/test controller and the per-project wrappers plus the external output mux.

Parameters:
- N_PROJ, 16, number of projects behind the mux.
- SEL_W, 4, project select width; must satisfy 2**SEL_W >= N_PROJ.
- HALF_CYC, 2, system clocks per project-clock phase (>=1).
- CNT_W, 8, width of the pulse-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver can accept a command.
- cmd_sel  in  SEL_W  target project index.
- cmd_ui  in  8  ui_in value to apply.
- cmd_uio  in  8  uio_in value to apply.
- cmd_prst  in  1  1 = hold project rst_n low for this command.
- cmd_ncyc  in  CNT_W  number of project-clock pulses.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_uo  out  8  sampled uo_out.
- rsp_uio  out  8  sampled uio_out.
- rsp_oe  out  8  sampled uio_oe.
- rsp_err  out  1  cmd_sel >= N_PROJ.
- proj_sel  out  SEL_W  select for the external output mux.
- proj_ena  out  N_PROJ  one-hot project enable.
- proj_iw  out  18  packed project input word.
- proj_ow  in  24  packed output of the selected project, via the external mux.

Behaviour:
- Packing, proj_iw: [17:10] uio_in, [9:2] ui_in, [1] rst_n, [0] clk.
- Unpacking, proj_ow: [23:16] uio_oe, [15:8] uio_out, [7:0] uo_out.
- Reset (rst high at a clk edge) forces, from the next cycle:
  - state IDLE;
  - proj_iw=0, so project clk is low and project rst_n is low;
  - proj_ena=0, proj_sel=0;
  - rsp_*=0, cmd_ready=0 while rst is high.
  - Reset mid-command aborts the command immediately; no response is produced.
- States: IDLE -> SETUP -> HIGH -> LOW -> (HIGH | SAMPLE) -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1; it is 1 only in IDLE.
  - On cmd_valid&&cmd_ready (cycle T), register all cmd fields.
  - proj_sel <= cmd_sel.
  - proj_ena <= onehot(cmd_sel), or all-zero if cmd_sel >= N_PROJ.
  - proj_iw <= {cmd_uio, cmd_ui, ~cmd_prst, 1'b0}.
  - Pulse counter loads cmd_ncyc. Go to SETUP.
- SETUP: HALF_CYC cycles with clk bit 0. Then HIGH if ncyc != 0, else SAMPLE.
- HIGH: clk bit 1 for HALF_CYC cycles, then LOW.
- LOW:
  - clk bit 0 for HALF_CYC cycles; counter decrements on exit.
  - Exit to HIGH if remaining > 0, else SAMPLE.
- SAMPLE: one cycle; proj_ow and the error flag are registered into rsp_* at its end.
- RESP:
  - rsp_valid=1, with rsp_* stable until rsp_valid&&rsp_ready.
  - Then IDLE in the next cycle.
  - rsp_ready while not valid is ignored.
- Latency: rsp_valid first high at T + HALF_CYC*(1 + 2*ncyc) + 2.
- Pulse count: exactly ncyc rising edges on proj_iw[0]. ncyc=0 gives no edge, a combinational read only.
- Between commands:
  - proj_iw holds the last command's values with clk=0.
  - proj_ena and proj_sel hold their last values.
  - Project state is thus preserved across commands.
- Error command (cmd_sel >= N_PROJ):
  - Runs the full timing sequence; proj_ena=0.
  - rsp_err=1, rsp_* data=0.
- All outputs are registered; no combinational path from cmd_* or rsp_ready to any output other than via state.

Decomposition:
- Package mux_drv_pkg holds:
  - IW_W=18, OW_W=24;
  - bit offsets IW_CLK=0, IW_RSTN=1, IW_UI=2, IW_UIO=10, OW_UO=0, OW_UIO=8, OW_OE=16;
  - state enum {IDLE, SETUP, HIGH, LOW, SAMPLE, RESP}.
- Sub-module mux_drv_phase_timer: loadable down-counter of HALF_CYC, asserting done on its last cycle; used by the SETUP, HIGH and LOW states.

Test Plan:
- Reset, then cmd sel=3, ui=0xA5, uio=0x3C, prst=0, ncyc=1, default params -> proj_ena=0x0008 and proj_iw=0x0F296 from T+1. Exactly one clk high at T+3..T+4. rsp_valid at T+8 with rsp_uo/uio/oe equal to proj_ow fields driven by the bench model.
- Bench model is an 8-bit counter exposed on uo_out; cmd ncyc=5 then ncyc=0 -> rsp_uo=5, then rsp_uo=5 again (no edge on the second command). Verify the second rsp_valid arrives at T+4.
- cmd prst=1, ncyc=2 -> proj_iw[1]=0 for the whole command. Counter model held at 0; rsp_uo=0. Next command with prst=0 restores rst_n=1.
- cmd sel=16 (N_PROJ=16) -> proj_ena=0, rsp_err=1, rsp data=0, timing unchanged.
- Hold rsp_ready low 10 cycles -> rsp_valid and data stable, cmd_ready=0. Then a rsp_ready pulse -> cmd_ready=1 the cycle after.
- Assert rst during HIGH of an ncyc=4 command -> next cycle proj_iw=0, proj_ena=0, rsp_valid never asserted. A new command after reset completes normally.
